// File: rtl/seg_scan_driver.sv
// 8-digit 7-segment scan driver: double-buffered frame, registered seg/cat outputs.
// Optional blink support enabled by defining SEG_BLINK_EN.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_en,
    input  logic        load,
    input  logic [31:0] frame_code,
    input  logic [7:0]  frame_blank,
    input  logic [7:0]  frame_dp,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  seg,
    output logic [7:0]  cat,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      act_code_q, act_code_d, pend_code_q, pend_code_d;
    logic [7:0]       act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic [7:0]       act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic             busy_q, busy_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       cat_q, cat_d;

    logic             div_end;
    logic             wrap;
    logic             visible;
    logic [3:0]       cur_code;

    function automatic logic [6:0] hex7(input logic [3:0] code);
        case (code)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign div_end  = (div_q == DIV_LAST);
    assign wrap     = div_end && (idx_q == 3'd7);
    assign cur_code = act_code_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_BLINK_EN
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [BLK_W-1:0] fcnt_q, fcnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (fcnt_q == BLK_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign visible = phase_q || !blink_mask[idx_q];
`else
    logic unused_blink;
    assign unused_blink = (^blink_mask) ^ (BLINK_DIV == 0);
    assign visible      = 1'b1;
`endif

    always_comb begin
        div_d        = div_end ? '0 : div_q + 1'b1;
        idx_d        = div_end ? idx_q + 3'd1 : idx_q;
        pend_code_d  = pend_code_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        act_code_d   = act_code_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        busy_d       = busy_q;

        if (load) begin
            pend_code_d  = frame_code;
            pend_blank_d = frame_blank;
            pend_dp_d    = frame_dp;
            busy_d       = 1'b1;
        end

        // A load landing on the wrap edge bypasses the pending buffer.
        if (wrap) begin
            busy_d = 1'b0;
            if (load) begin
                act_code_d  = frame_code;
                act_blank_d = frame_blank;
                act_dp_d    = frame_dp;
            end else if (busy_q) begin
                act_code_d  = pend_code_q;
                act_blank_d = pend_blank_q;
                act_dp_d    = pend_dp_q;
            end
        end

        seg_d = '0;
        cat_d = '1;
        if (disp_en) begin
            cat_d = ~(8'h01 << idx_q);
            if (visible) begin
                seg_d[7]   = act_dp_q[idx_q];
                seg_d[6:0] = act_blank_q[idx_q] ? 7'h00 : hex7(cur_code);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            idx_q        <= '0;
            act_code_q   <= '0;
            act_blank_q  <= '1;
            act_dp_q     <= '0;
            pend_code_q  <= '0;
            pend_blank_q <= '1;
            pend_dp_q    <= '0;
            busy_q       <= 1'b0;
            seg_q        <= '0;
            cat_q        <= '1;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            act_code_q   <= act_code_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            pend_code_q  <= pend_code_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            busy_q       <= busy_d;
            seg_q        <= seg_d;
            cat_q        <= cat_d;
        end
    end

    assign seg        = seg_q;
    assign cat        = cat_q;
    assign busy       = busy_q;
    assign frame_done = wrap;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4 (one frame = 32 cycles).
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_en = 1'b1;
    logic        load = 1'b0;
    logic [31:0] frame_code = '0;
    logic [7:0]  frame_blank = '0;
    logic [7:0]  frame_dp = '0;
    logic [7:0]  blink_mask = '0;
    logic [7:0]  seg, cat;
    logic        busy, frame_done;

    int checks = 0;
    int failures = 0;
    int m;

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .load(load),
        .frame_code(frame_code), .frame_blank(frame_blank), .frame_dp(frame_dp),
        .blink_mask(blink_mask), .seg(seg), .cat(cat), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Edges since reset release; sampled on the falling edge this equals edge count m.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= 0;
        else        m <= m + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic wait_to(input int t);
        while (m < t) @(negedge clk);
    endtask

    task automatic drive_load(input logic [31:0] c, input logic [7:0] b, input logic [7:0] d);
        frame_code = c; frame_blank = b; frame_dp = d; load = 1'b1;
    endtask

    task automatic test_reset;
        logic [7:0] exp_cat;
        logic       exp_fd;
        repeat (3) @(negedge clk);
        checks++;
        if (cat !== 8'hFF || seg !== 8'h00 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state cat=%h seg=%h busy=%b fd=%b required FF 00 0 0", cat, seg, busy, frame_done);
        end
        rst_n = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            wait_to(t);
            exp_cat = ~(8'h01 << (((t - 1) / 4) % 8));
            exp_fd  = (t % 32 == 31);
            checks++;
            if (cat !== exp_cat || seg !== 8'h00 || frame_done !== exp_fd) begin
                failures++;
                $display("FAIL reset_walk m=%0d cat=%h seg=%h fd=%b required %h 00 %b", t, cat, seg, frame_done, exp_cat, exp_fd);
            end
        end
    endtask

    task automatic test_load;
        wait_to(32);
        drive_load(32'h76543210, 8'h00, 8'h01);
        wait_to(33);
        load = 1'b0;
        for (int t = 33; t <= 63; t++) begin
            wait_to(t);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL load_busy m=%0d busy=%b required 1", t, busy);
            end
        end
        wait_to(64);
        checks++;
        if (busy !== 1'b0 || seg !== 8'h00) begin
            failures++;
            $display("FAIL load_apply m=64 busy=%b seg=%h required 0 00", busy, seg);
        end
        wait_to(65);
        checks++;
        if (cat !== 8'hFE || seg !== 8'hBF) begin
            failures++;
            $display("FAIL load_d0 cat=%h seg=%h required FE BF", cat, seg);
        end
        wait_to(69);
        checks++;
        if (cat !== 8'hFD || seg !== 8'h06) begin
            failures++;
            $display("FAIL load_d1 cat=%h seg=%h required FD 06", cat, seg);
        end
        wait_to(73);
        checks++;
        if (cat !== 8'hFB || seg !== 8'h5B) begin
            failures++;
            $display("FAIL load_d2 cat=%h seg=%h required FB 5B", cat, seg);
        end
        wait_to(93);
        checks++;
        if (cat !== 8'h7F || seg !== 8'h07) begin
            failures++;
            $display("FAIL load_d7 cat=%h seg=%h required 7F 07", cat, seg);
        end
    endtask

    task automatic test_latest_wins;
        wait_to(99);
        drive_load(32'h11111111, 8'h00, 8'h00);
        wait_to(100);
        load = 1'b0;
        wait_to(101);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL lw_busy1 busy=%b required 1", busy);
        end
        wait_to(110);
        drive_load(32'h22222222, 8'h00, 8'h00);
        wait_to(111);
        load = 1'b0;
        wait_to(127);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL lw_busy2 busy=%b required 1", busy);
        end
        wait_to(128);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL lw_clear busy=%b required 0", busy);
        end
        for (int t = 129; t <= 160; t++) begin
            wait_to(t);
            checks++;
            if (seg !== 8'h5B) begin
                failures++;
                $display("FAIL lw_seg m=%0d seg=%h required 5B", t, seg);
            end
        end
    endtask

    task automatic test_load_on_wrap;
        wait_to(191);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wrap_pre fd=%b busy=%b required 1 0", frame_done, busy);
        end
        drive_load(32'h89ABCDEF, 8'h00, 8'h00);
        wait_to(192);
        load = 1'b0;
        for (int t = 192; t <= 196; t++) begin
            wait_to(t);
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL wrap_busy m=%0d busy=%b required 0", t, busy);
            end
            if (t == 193) begin
                checks++;
                if (cat !== 8'hFE || seg !== 8'h71) begin
                    failures++;
                    $display("FAIL wrap_d0 cat=%h seg=%h required FE 71", cat, seg);
                end
            end
        end
        wait_to(197);
        checks++;
        if (cat !== 8'hFD || seg !== 8'h79) begin
            failures++;
            $display("FAIL wrap_d1 cat=%h seg=%h required FD 79", cat, seg);
        end
    endtask

    task automatic test_disp_off;
        logic exp_fd;
        wait_to(200);
        disp_en = 1'b0;
        for (int t = 201; t <= 289; t++) begin
            wait_to(t);
            exp_fd = (t % 32 == 31);
            checks++;
            if (cat !== 8'hFF || seg !== 8'h00 || frame_done !== exp_fd) begin
                failures++;
                $display("FAIL off_state m=%0d cat=%h seg=%h fd=%b required FF 00 %b", t, cat, seg, frame_done, exp_fd);
            end
            if (t == 250) drive_load(32'h00000000, 8'h00, 8'h00);
            if (t == 251) begin
                load = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL off_busy busy=%b required 1", busy);
                end
            end
            if (t == 256) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL off_apply busy=%b required 0", busy);
                end
            end
        end
        wait_to(290);
        disp_en = 1'b1;
        wait_to(291);
        checks++;
        if (cat !== 8'hFE || seg !== 8'h3F) begin
            failures++;
            $display("FAIL on_resume cat=%h seg=%h required FE 3F", cat, seg);
        end
        wait_to(295);
        checks++;
        if (cat !== 8'hFD || seg !== 8'h3F) begin
            failures++;
            $display("FAIL on_next cat=%h seg=%h required FD 3F", cat, seg);
        end
    endtask

    task automatic test_blank_dp;
        wait_to(300);
        drive_load(32'h00000005, 8'h01, 8'h03);
        wait_to(301);
        load = 1'b0;
        wait_to(321);
        checks++;
        if (cat !== 8'hFE || seg !== 8'h80) begin
            failures++;
            $display("FAIL blank_d0 cat=%h seg=%h required FE 80", cat, seg);
        end
        wait_to(325);
        checks++;
        if (cat !== 8'hFD || seg !== 8'hBF) begin
            failures++;
            $display("FAIL blank_d1 cat=%h seg=%h required FD BF", cat, seg);
        end
    endtask

    task automatic test_async_reset;
        wait_to(330);
        drive_load(32'h00000000, 8'h00, 8'hFF);
        wait_to(331);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ar_busy busy=%b required 1", busy);
        end
        wait_to(335);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cat !== 8'hFF || seg !== 8'h00 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL ar_immediate cat=%h seg=%h busy=%b fd=%b required FF 00 0 0", cat, seg, busy, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 33; t <= 40; t++) begin
            wait_to(t);
            checks++;
            if (seg !== 8'h00) begin
                failures++;
                $display("FAIL ar_discard m=%0d seg=%h required 00", t, seg);
            end
        end
        checks++;
        if (cat !== 8'hFD) begin
            failures++;
            $display("FAIL ar_cat cat=%h required FD", cat);
        end
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        blink_mask = 8'h01;
        drive_load(32'h00000000, 8'h00, 8'h01);
        wait_to(1);
        load = 1'b0;
        wait_to(33);
        checks++;
        if (cat !== 8'hFE || seg !== 8'hBF) begin
            failures++;
            $display("FAIL blink_f2 cat=%h seg=%h required FE BF", cat, seg);
        end
        wait_to(65);
        checks++;
        if (cat !== 8'hFE || seg !== 8'h00) begin
            failures++;
            $display("FAIL blink_f3 cat=%h seg=%h required FE 00", cat, seg);
        end
        wait_to(69);
        checks++;
        if (cat !== 8'hFD || seg !== 8'h3F) begin
            failures++;
            $display("FAIL blink_f3_d1 cat=%h seg=%h required FD 3F", cat, seg);
        end
        wait_to(97);
        checks++;
        if (cat !== 8'hFE || seg !== 8'h00) begin
            failures++;
            $display("FAIL blink_f4 cat=%h seg=%h required FE 00", cat, seg);
        end
        wait_to(129);
        checks++;
        if (cat !== 8'hFE || seg !== 8'hBF) begin
            failures++;
            $display("FAIL blink_f5 cat=%h seg=%h required FE BF", cat, seg);
        end
        wait_to(161);
        checks++;
        if (cat !== 8'hFE || seg !== 8'hBF) begin
            failures++;
            $display("FAIL blink_f6 cat=%h seg=%h required FE BF", cat, seg);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_latest_wins();
        test_load_on_wrap();
        test_disp_off();
        test_blank_dp();
        test_async_reset();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
